// File: rtl/ipg_wreq_assembler_if.sv
// Chunk-receive and memory-write signal bundle for ipg_wreq_assembler.
// The slave modport is the assembler; master is the IPG receive / memory side.
interface ipg_wreq_assembler_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int LEN_WIDTH   = 7,
  parameter int HDR_WIDTH   = 16,
  parameter int ADR_WIDTH   = 12,
  parameter int MAX_PAYLOAD = 512
);
  logic [DATA_WIDTH-1:0]  rx_ipg_data;
  logic [LEN_WIDTH-1:0]   rx_len;
  logic                   wreq_valid;
  logic                   rx_ready;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [ADR_WIDTH-1:0]   wr_addr;
  logic [HDR_WIDTH-1:0]   wr_len;
  logic [MAX_PAYLOAD-1:0] wr_data;
  logic                   err;
  logic [1:0]             err_code;
  logic [15:0]            done_count;

  modport master (
    output rx_ipg_data, rx_len, wreq_valid, wr_ready,
    input  rx_ready, wr_valid, wr_addr, wr_len, wr_data, err, err_code, done_count
  );

  modport slave (
    input  rx_ipg_data, rx_len, wreq_valid, wr_ready,
    output rx_ready, wr_valid, wr_addr, wr_len, wr_data, err, err_code, done_count
  );
endinterface

// File: rtl/ipg_wreq_assembler.sv
// Parses a length/address header from the first IPG chunk, assembles the payload
// MSB-first and presents one complete write over a valid/ready handshake.
module ipg_wreq_assembler #(
  parameter int DATA_WIDTH  = 64,
  parameter int LEN_WIDTH   = 7,
  parameter int HDR_WIDTH   = 16,
  parameter int ADR_WIDTH   = 12,
  parameter int MAX_PAYLOAD = 512,
  parameter int TIMEOUT     = 1024
) (
  input  logic clk,
  input  logic reset,
  ipg_wreq_assembler_if.slave bus
);
  localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_OUT} state_t;

  state_t                 state_q;
  logic [MAX_PAYLOAD-1:0] buf_q;
  logic [HDR_WIDTH-1:0]   rem_q;
  logic [HDR_WIDTH-1:0]   len_q;
  logic [ADR_WIDTH-1:0]   addr_q;
  logic [IW-1:0]          idle_q;
  logic                   rx_ready_q;
  logic                   wr_valid_q;
  logic                   err_q;
  logic [1:0]             code_q;
  logic [15:0]            done_q;

  logic                   accept;
  logic [LEN_WIDTH-1:0]   eff_len;
  logic [HDR_WIDTH-1:0]   take;
  logic [HDR_WIDTH-1:0]   plen;
  logic [ADR_WIDTH-1:0]   hdr_addr;
  logic [DATA_WIDTH-1:0]  chunk_top;
  logic [MAX_PAYLOAD-1:0] buf_d;
  logic                   timeout_hit;

  always_comb begin
    accept    = bus.wreq_valid && rx_ready_q && (bus.rx_len != '0);
    eff_len   = (bus.rx_len > LEN_WIDTH'(DATA_WIDTH)) ? LEN_WIDTH'(DATA_WIDTH) : bus.rx_len;
    take      = (HDR_WIDTH'(eff_len) < rem_q) ? HDR_WIDTH'(eff_len) : rem_q;
    plen      = bus.rx_ipg_data[DATA_WIDTH-1 -: HDR_WIDTH];
    hdr_addr  = bus.rx_ipg_data[DATA_WIDTH-1-HDR_WIDTH -: ADR_WIDTH];
    chunk_top = bus.rx_ipg_data >> (DATA_WIDTH - 32'(take));
    // Shift-accumulating MSB-first leaves the first payload bit at [plen-1] once
    // all plen bits have arrived, the same as indexed placement from the top.
    buf_d       = (buf_q << take) | MAX_PAYLOAD'(chunk_top);
    timeout_hit = (TIMEOUT != 0) && ((idle_q + 1'b1) == IW'(TIMEOUT));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      buf_q      <= '0;
      rem_q      <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      idle_q     <= '0;
      rx_ready_q <= 1'b1;
      wr_valid_q <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= '0;
      done_q     <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (eff_len < LEN_WIDTH'(HDR_WIDTH + ADR_WIDTH)) begin
              err_q  <= 1'b1;
              code_q <= 2'd3;
            end else if ((plen == '0) || (32'(plen) > MAX_PAYLOAD)) begin
              err_q  <= 1'b1;
              code_q <= 2'd1;
            end else begin
              addr_q  <= hdr_addr;
              len_q   <= plen;
              rem_q   <= plen;
              buf_q   <= '0;
              idle_q  <= '0;
              state_q <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (accept) begin
            buf_q  <= buf_d;
            rem_q  <= rem_q - take;
            idle_q <= '0;
            if (rem_q == take) begin
              state_q    <= S_OUT;
              wr_valid_q <= 1'b1;
              rx_ready_q <= 1'b0;
            end
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            code_q  <= 2'd2;
            buf_q   <= '0;
            idle_q  <= '0;
            state_q <= S_IDLE;
          end else begin
            idle_q <= idle_q + 1'b1;
          end
        end
        S_OUT: begin
          if (bus.wr_ready) begin
            wr_valid_q <= 1'b0;
            rx_ready_q <= 1'b1;
            done_q     <= done_q + 16'd1;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.rx_ready   = rx_ready_q;
  assign bus.wr_valid   = wr_valid_q;
  assign bus.wr_addr    = addr_q;
  assign bus.wr_len     = len_q;
  assign bus.wr_data    = buf_q;
  assign bus.err        = err_q;
  assign bus.err_code   = code_q;
  assign bus.done_count = done_q;
endmodule

// File: doc/ipg_wreq_assembler.md
Name: ipg_wreq_assembler

Overview:
Parametrised successor to the IPG write-request receiver. Accepts variable-length bit chunks carried in the inter-packet gap and parses a header of length and address from the first chunk. Assembles the payload bits MSB-first into a buffer, then presents one complete write (addr, len, data) to the memory side over a valid/ready handshake. Adds length checking, an inter-chunk timeout, receive backpressure and a completed-write counter. Sits between the IPG receive datapath and the remote-memory write port.

Parameters:
DATA_WIDTH  64  width of rx_ipg_data chunk
LEN_WIDTH  7  width of rx_len; must hold 0..DATA_WIDTH
HDR_WIDTH  16  payload-length field width, in bits
ADR_WIDTH  12  write address field width
MAX_PAYLOAD  512  payload buffer size, in bits
TIMEOUT  1024  maximum idle cycles between payload chunks; 0 disables the timeout

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
rx_ipg_data  in  DATA_WIDTH  chunk; valid bits are MSB-aligned
rx_len  in  LEN_WIDTH  number of valid bits in the chunk
wreq_valid  in  1  chunk qualifier
rx_ready  out  1  block can accept a chunk
wr_valid  out  1  assembled write is available
wr_ready  in  1  memory side accepts the write
wr_addr  out  ADR_WIDTH  write address
wr_len  out  HDR_WIDTH  payload length, in bits
wr_data  out  MAX_PAYLOAD  payload, right-aligned in bits [wr_len-1:0]; upper bits zero
err  out  1  one-cycle error pulse
err_code  out  2  error cause: 1 = bad length, 2 = timeout, 3 = short header; held until the next error
done_count  out  16  count of completed writes; wraps at 2^16

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE and the buffer is cleared.
  - rx_ready=1, wr_valid=0, wr_addr=0, wr_len=0, wr_data=0, err=0, err_code=0, done_count=0.
- Chunk acceptance:
  - A chunk is accepted when wreq_valid && rx_ready && rx_len != 0.
  - rx_len=0 with wreq_valid high is ignored.
  - rx_len > DATA_WIDTH is treated as DATA_WIDTH.
- IDLE, on an accepted chunk:
  - If rx_len < HDR_WIDTH+ADR_WIDTH: err pulse, err_code=3, stay in IDLE.
  - Otherwise plen = rx_ipg_data[DATA_WIDTH-1 -: HDR_WIDTH] and addr = the next ADR_WIDTH bits below it.
  - If plen==0 or plen > MAX_PAYLOAD: err pulse, err_code=1, stay in IDLE.
  - Otherwise latch addr and plen, set remaining=plen, clear the buffer, go to PAYLOAD.
  - Any header-chunk bits below the address field are discarded.
- PAYLOAD, on an accepted chunk:
  - Let n = min(rx_len, remaining).
  - For i=1..n, buffer[remaining-i] = rx_ipg_data[DATA_WIDTH-i]; then remaining -= n.
  - Chunk bits beyond remaining are discarded.
  - When remaining reaches 0, go to OUT.
- PAYLOAD timeout:
  - The idle counter resets on every accepted chunk and increments otherwise.
  - When it reaches TIMEOUT (TIMEOUT != 0): err pulse, err_code=2, discard the partial payload, go to IDLE.
- OUT:
  - wr_valid is asserted the cycle after the last payload chunk is accepted (latency 1), with wr_addr, wr_len and wr_data stable and rx_ready=0.
  - Outputs hold until wr_ready. Incoming chunks are not accepted (upstream must respect rx_ready).
  - On wr_valid && wr_ready: wr_valid drops the next cycle, done_count increments, state goes to IDLE, and rx_ready=1 from the next cycle.
- rx_ready = 1 in IDLE and PAYLOAD, 0 in OUT.
- err is registered: it is high for exactly one cycle, the cycle after the offending event.
- wr_data reflects the buffer only while wr_valid is high; its contents at other times are don't-care but must be deterministic (zero after reset).
- Reset mid-PAYLOAD or mid-OUT: the write is lost, no err is raised, done_count returns to 0.
- Back-to-back operation: a new header may be accepted in the cycle after the handshake completes. No header can overlap the OUT state.

Test Plan:
- Basic write, TIMEOUT=0: header chunk rx_len=28 with len=64, addr=0xABC, then one chunk rx_len=64, data=0x0123456789ABCDEF, wr_ready=1 -> wr_valid high 1 cycle after the payload chunk; wr_addr=0xABC, wr_len=64, wr_data[63:0]=0x0123456789ABCDEF, upper bits 0; done_count=1.
- Fragmented payload: len=100, chunks of rx_len 30/30/30/30 -> four chunks accepted; last 20 bits of the final chunk dropped; wr_data[99:0] equals the concatenated first 100 bits; one write issued.
- Backpressure: hold wr_ready=0 for 5 cycles while driving wreq_valid -> rx_ready=0, outputs stable, no chunk consumed; wr_ready=1 -> handshake completes, then rx_ready=1 and the next header is accepted.
- Error cases:
  - len=0 -> err pulse, err_code=1.
  - len=513 -> err pulse, err_code=1.
  - header chunk rx_len=20 -> err pulse, err_code=3.
  - In all three: state stays IDLE and wr_valid never rises.
- Timeout: TIMEOUT=8, header len=128, one 64-bit chunk, then 8 idle cycles -> err pulse with err_code=2; a following valid header is processed normally.
- Reset mid-payload: assert reset asynchronously between payload chunks -> wr_valid=0, rx_ready=1, done_count=0 immediately; no err pulse.
